// File: rtl/sound_pkg.sv
// sound_pkg: shared definitions for the sound arbiter.
//   - request ids (bit positions in req/pending)
//   - FSM state encoding
//   - note half-periods at 100 MHz, per-id sequence length and note ROM
//   - fixed-priority grant helper
package sound_pkg;

   localparam logic [1:0] ID_TICK  = 2'd0;
   localparam logic [1:0] ID_GOAL  = 2'd1;
   localparam logic [1:0] ID_START = 2'd2;
   localparam logic [1:0] ID_OVER  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [16:0] HP_G5 = 17'd63776;
   localparam logic [16:0] HP_E5 = 17'd75873;
   localparam logic [16:0] HP_C5 = 17'd95602;
   localparam logic [16:0] HP_A4 = 17'd113636;
   localparam logic [16:0] HP_C6 = 17'd47755;

   function automatic logic [2:0] seq_len(input logic [1:0] id);
      case (id)
         ID_OVER:  seq_len = 3'd4;
         ID_START: seq_len = 3'd3;
         ID_GOAL:  seq_len = 3'd2;
         default:  seq_len = 3'd1;
      endcase
   endfunction

   function automatic logic [16:0] note_hp(input logic [1:0] id, input logic [1:0] idx);
      note_hp = HP_A4;
      case (id)
         ID_OVER: begin
            case (idx)
               2'd0:    note_hp = HP_G5;
               2'd1:    note_hp = HP_E5;
               2'd2:    note_hp = HP_C5;
               default: note_hp = HP_A4;
            endcase
         end
         ID_START: begin
            case (idx)
               2'd0:    note_hp = HP_C5;
               2'd1:    note_hp = HP_E5;
               default: note_hp = HP_G5;
            endcase
         end
         ID_GOAL: note_hp = HP_C6;
         default: note_hp = HP_A4;
      endcase
   endfunction

   // Fixed priority: OVER > START > GOAL > TICK.
   function automatic logic [1:0] top_id(input logic [3:0] p);
      if (p[ID_OVER])       top_id = ID_OVER;
      else if (p[ID_START]) top_id = ID_START;
      else if (p[ID_GOAL])  top_id = ID_GOAL;
      else                  top_id = ID_TICK;
   endfunction

endpackage

// File: rtl/sound_arbiter_tone_gen.sv
// tone_gen: square-wave generator for the current note.
//   clk, rst_n : system clock, async active-low reset
//   clr        : synchronous clear of counter and output (wins over run)
//   run        : advance the half-period counter
//   hp         : half-period in cycles (>= 1)
//   tone       : square-wave output, toggles every hp cycles
module tone_gen
   import sound_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        run,
   input  logic [16:0] hp,
   output logic        tone
);

   logic [16:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else if (run) begin
         if (cnt == hp - 17'd1) begin
            cnt  <= '0;
            tone <= ~tone;
         end else begin
            cnt <= cnt + 17'd1;
         end
      end
   end

endmodule

// File: rtl/sound_arbiter.sv
// sound_arbiter: latches one-cycle sound requests, grants the audio output
// to the highest-priority pending request and plays its note sequence on
// the PmodAMP2.
//   clk, rst_n : system clock, async active-low reset
//   en         : sound enable (sw0); low clears everything and silences
//   req[3:0]   : request pulses, [3] OVER [2] START [1] GOAL [0] TICK
//   busy       : a sequence (notes and gaps) is playing
//   cur_id     : id being played, valid while busy
//   pmod1      : square-wave audio
//   pmod2      : gain select, tied high
//   pmod4      : amplifier shutdown_n, follows busy
//
// state | meaning
// IDLE  | nothing playing; grants highest pending id
// PLAY  | tone running for NOTE_CYC cycles
// GAP   | silent for GAP_CYC cycles, then next note or IDLE
module sound_arbiter
   import sound_pkg::*;
#(
   parameter int NOTE_CYC = 15_000_000,
   parameter int GAP_CYC  = 5_000_000,
   parameter int HP_SHIFT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   output logic       busy,
   output logic [1:0] cur_id,
   output logic       pmod1,
   output logic       pmod2,
   output logic       pmod4
);

   localparam logic [23:0] NOTE_LAST = 24'(NOTE_CYC - 1);
   localparam logic [23:0] GAP_LAST  = 24'(GAP_CYC - 1);

   state_t      state;
   logic [3:0]  pending;
   logic [3:0]  pend_nxt;
   logic [3:0]  clr_mask;
   logic [1:0]  note_idx;
   logic [23:0] cnt;
   logic        preempt;
   logic        grant_now;
   logic        note_done;
   logic        gap_done;
   logic        last_note;
   logic        tone_clr;
   logic        tone_run;
   logic [16:0] hp_raw;
   logic [16:0] hp;

   assign hp_raw = note_hp(cur_id, note_idx) >> HP_SHIFT;
   assign hp     = (hp_raw == '0) ? 17'd1 : hp_raw;

   assign preempt   = pending[ID_OVER] && (state != ST_IDLE) && (cur_id != ID_OVER);
   assign grant_now = (state == ST_IDLE) && (pending != '0);
   assign note_done = (state == ST_PLAY) && (cnt == NOTE_LAST);
   assign gap_done  = (state == ST_GAP) && (cnt == GAP_LAST);
   assign last_note = ({1'b0, note_idx} == seq_len(cur_id) - 3'd1);

   // Set is ORed in after the clear so a new request for the id being
   // granted on the same edge survives.
   always_comb begin
      clr_mask = '0;
      if (grant_now)
         clr_mask[top_id(pending)] = 1'b1;
      else if (preempt)
         clr_mask[ID_OVER] = 1'b1;
      pend_nxt = (pending & ~clr_mask) | req;
   end

   // Tone restarts from 0 on every note entry; GAP/IDLE hold it cleared.
   assign tone_clr = !en || (state != ST_PLAY) || preempt || note_done;
   assign tone_run = (state == ST_PLAY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         pending  <= '0;
         cur_id   <= ID_TICK;
         note_idx <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
      end else if (!en) begin
         state   <= ST_IDLE;
         pending <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
      end else begin
         pending <= pend_nxt;
         if (preempt) begin
            cur_id   <= ID_OVER;
            note_idx <= '0;
            cnt      <= '0;
            state    <= ST_PLAY;
            busy     <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (grant_now) begin
                     cur_id   <= top_id(pending);
                     note_idx <= '0;
                     cnt      <= '0;
                     state    <= ST_PLAY;
                     busy     <= 1'b1;
                  end
               end
               ST_PLAY: begin
                  if (note_done) begin
                     cnt   <= '0;
                     state <= ST_GAP;
                  end else begin
                     cnt <= cnt + 24'd1;
                  end
               end
               ST_GAP: begin
                  if (gap_done) begin
                     cnt <= '0;
                     if (last_note) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end else begin
                        note_idx <= note_idx + 2'd1;
                        state    <= ST_PLAY;
                     end
                  end else begin
                     cnt <= cnt + 24'd1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   tone_gen u_tone_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tone_clr),
      .run   (tone_run),
      .hp    (hp),
      .tone  (pmod1)
   );

   assign pmod2 = 1'b1;
   assign pmod4 = busy;

endmodule

// File: doc/sound_arbiter.md
# sound_arbiter

Arbiter and sequencer for the single PmodAMP2 audio output. It accepts one-cycle sound requests from the game FSM: game over, game start, goal scored and countdown tick. It latches them, grants the output to the highest-priority pending request, and plays that request's fixed note sequence as a square wave. It sits between `fsm` and the `pmod_1/pmod_2/pmod_4` pins and replaces the FSM's direct drive of those pins.

## Interface
- `NOTE_CYC`, 15_000_000: clock cycles per note (150 ms at 100 MHz).
- `GAP_CYC`, 5_000_000: silent cycles after every note.
- `HP_SHIFT`, 0: right shift applied to the note half-period table, used to shorten tones in simulation. Any result below 1 is clamped to 1.

- `clk` in 1: 100 MHz system clock; the block has this single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: sound enable, driven from `sw0`.
- `req` in 4: one-cycle request pulses. [3] OVER, [2] START, [1] GOAL, [0] TICK.
- `busy` out 1: high while a sequence plays, including gaps.
- `cur_id` out 2: index of the request being played; valid only while `busy` is high.
- `pmod1` out 1: square-wave audio (AIN).
- `pmod2` out 1: gain select; constant 1 (6 dB).
- `pmod4` out 1: amplifier enable (SHUTDOWN_n); high only while `busy` is high.

## Operation
- **Reset values:** `pending`=0, state IDLE, `busy`=0, `cur_id`=0, `pmod1`=0, `pmod4`=0, `pmod2`=1.
- **Request latching:**
  - `pending[i]` is set at the first edge where `req[i]`=1 and `en`=1.
  - Repeated requests for an already-pending id merge into that one bit.
- **Priority:** fixed, OVER > START > GOAL > TICK.
- **States:** IDLE, PLAY, GAP.
- **IDLE:**
  - With `pending`≠0: grant the highest pending id, clear its bit, set `cur_id`, load note 0, go to PLAY.
  - If a set and a clear of the same bit happen on the same edge, the set wins.
- **PLAY:**
  - Tone generator runs at the current note's half-period.
  - After `NOTE_CYC` cycles, go to GAP.
- **GAP:**
  - `pmod1` is forced to 0 and the tone counter is cleared.
  - After `GAP_CYC` cycles: if this was the last note, go to IDLE; otherwise go to PLAY with the next note.
- **Sequences** (half-periods in cycles at 100 MHz):
  - OVER: G5 63776, E5 75873, C5 95602, A4 113636.
  - START: C5, E5, G5.
  - GOAL: C6 47755, C6.
  - TICK: A4.
- **Preemption:**
  - A pending OVER while playing START, GOAL or TICK aborts that sequence at the next edge.
  - It then restarts in PLAY with OVER note 0, and the tone counter and `pmod1` are reset.
  - The aborted sequence is dropped.
  - No other request preempts.
- **Same id while playing:** the request is latched and replays after the current sequence ends.
- **`en`=0:** synchronously clears `pending`, forces IDLE and drives `pmod1`=`pmod4`=0 on the next edge. Requests are ignored while `en`=0.
- **Tone generator:**
  - A 17-bit counter; when it reaches `hp`-1, toggle `pmod1` and clear the counter.
  - `pmod1` starts at 0 on every note entry.
- **Counter widths:**
  - Note/gap counter is 24-bit.
  - Note index is 2-bit.
  - Sequence length comes from a table in the package.

## Timing
- `req` high at edge k: `pending` set at k.
  - If IDLE, PLAY is entered at edge k+1, and `busy`, `pmod4` and `cur_id` are valid after k+1.
- First `pmod1` toggle occurs `hp` cycles after PLAY entry.
- Each note occupies exactly `NOTE_CYC`+`GAP_CYC` cycles.
- A sequence of n notes keeps `busy` high for n·(`NOTE_CYC`+`GAP_CYC`) cycles, then holds IDLE for ≥1 cycle.
  - Back-to-back sequences are therefore separated by exactly one IDLE cycle.
- OVER preemption: OVER pulse at edge k, PLAY(OVER, note 0) from edge k+1.
- Asynchronous reset mid-sequence returns all outputs to their reset values immediately, with no completion of the current note.

## Structure
- Package `sound_pkg` holds:
  - request-id constants (`ID_OVER`=3 … `ID_TICK`=0);
  - state encoding;
  - note half-period constants;
  - per-id sequence length and note ROM as functions of (id, idx).
- Sub-module `tone_gen` contains the half-period counter and `pmod1` toggle, with clear and enable inputs.
- The arbiter, FSM and note counters stay in `sound_arbiter`.

## Test plan
All scenarios use `NOTE_CYC`=100, `GAP_CYC`=20, `HP_SHIFT`=14, which gives C5=5, A4=6 and C6=2 cycles.
- **TICK alone:** `req[0]` pulse → `busy`=1 for 120 cycles, `cur_id`=0, `pmod1` toggles every 6 cycles for 100 cycles then 0 for 20, `pmod4` matches `busy`.
- **Simultaneous requests:** `req`=4'b0110 in one cycle → START plays (360 cycles), one IDLE cycle, then GOAL plays (240 cycles).
- **OVER preemption:** GOAL at cycle 0, OVER at cycle 50 → at cycle 51 `cur_id`=3 with note 0 restarted; GOAL never resumes; total `busy` ends at cycle 531.
- **Merged and replayed requests:** three TICK pulses during a TICK sequence → exactly one extra TICK after the current one.
- **Enable low:** `en`=0 mid-START → next edge `busy`=0, `pmod1`=`pmod4`=0, `pending`=0; a request while `en`=0 produces no sound after `en` returns to 1.
- **Reset mid-note:** `rst_n` low mid-note → outputs at reset values immediately, `pmod2`=1 throughout.
